// File: rtl/cache_stub_pkg.sv
// Shared definitions for the cache_stub_mem responder: sequencer state
// encodings, latency counter width and the legal latency range.
package cache_stub_pkg;

  // Width of the per-access latency down-counter.
  localparam int LAT_W = 4;

  // Largest access latency the counter can express.
  localparam int LAT_MAX = (1 << LAT_W) - 1;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_I_ACC = 2'd1;
  localparam logic [1:0] ST_D_ACC = 2'd2;

endpackage

// File: rtl/cache_stub_ram.sv
// Single-port 32-bit word array with per-byte write enables and a
// synchronous read. One read per cycle is steered into either the icache or
// the dcache output register, so each port holds its last read word while
// the other port uses the array.
module cache_stub_ram #(
  parameter int    DEPTH_LOG2 = 12,
  parameter string MEM_HEX    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [3:0]            i_we,
  input  logic [31:0]           i_wdata,
  input  logic                  i_ld_i,
  input  logic                  i_ld_d,
  output logic [31:0]           o_rdata_i,
  output logic [31:0]           o_rdata_d
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  // Byte-lane writes into the array.
  // NOTE: the array has no reset branch; clearing thousands of words would
  // stop it mapping onto block RAM, and software never relies on it.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // Synchronous read into the requesting port's output register.
  // NOTE: sequential state is always updated with <=, so every register in
  // the same edge sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata_i <= '0;
      o_rdata_d <= '0;
    end else begin
      if (i_ld_i) o_rdata_i <= r_mem[i_idx];
      if (i_ld_d) o_rdata_d <= r_mem[i_idx];
    end
  end

endmodule

// File: rtl/cache_stub_mem.sv
// cache_stub_mem: stand-in for the icache/dcache + DDR2 system. Serialises
// the icache and dcache requests captured in one idle cycle (icache first),
// each access taking LATENCY cycles (1..15), and holds stall high until the
// last access completes. The capture edge counts as the first cycle of the
// first access, so LATENCY=1 behaves like a plain BRAM with no stall.
// Optional feature macro: CACHE_STUB_PERF_EN adds perf_stall_cycles and
// perf_accesses saturating counters.
module cache_stub_mem
  import cache_stub_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 12,
  parameter int    LATENCY    = 1,
  parameter string MEM_HEX    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] icache_addr,
  input  logic        icache_re,
  output logic [31:0] icache_dout,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall
`ifdef CACHE_STUB_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_accesses
`endif
);

  localparam int IDX_W = DEPTH_LOG2;
  localparam logic [LAT_W-1:0] LAT_FULL = LAT_W'(LATENCY - 1);

  // Sequencer state and the captured request.
  logic [1:0]       r_state;
  logic [LAT_W-1:0] r_cnt;
  logic             r_d_pend;
  logic             r_d_rd;
  logic [IDX_W-1:0] r_iidx;
  logic [IDX_W-1:0] r_didx;
  logic [3:0]       r_dwe;
  logic [31:0]      r_din;

  logic [IDX_W-1:0] w_in_iidx;
  logic [IDX_W-1:0] w_in_didx;
  logic             w_in_drd;
  logic             w_in_d;
  logic             w_act_i;
  logic             w_act_d;
  logic             w_d_pend;
  logic             w_d_rd;
  logic [LAT_W-1:0] w_cnt;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_we;
  logic [31:0]      w_wdata;
  logic             w_done;
  logic [1:0]       w_state_nx;
  logic [LAT_W-1:0] w_cnt_nx;
  logic [3:0]       w_ram_we;
  logic             w_ld_i;
  logic             w_ld_d;

  // Address bits outside the word index are don't-care; accesses alias.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{icache_addr[31:IDX_W+2], icache_addr[1:0],
                                dcache_addr[31:IDX_W+2], dcache_addr[1:0]};

  assign w_in_iidx = icache_addr[IDX_W+1:2];
  assign w_in_didx = dcache_addr[IDX_W+1:2];
  // A write takes precedence over a simultaneous read on the dcache port.
  assign w_in_drd  = dcache_re & ~(|dcache_we);
  assign w_in_d    = dcache_re | (|dcache_we);

  // Select the access in progress this cycle: straight from the ports while
  // idle (capture cycle), from the captured request otherwise. w_cnt is the
  // number of further edges the access needs after this one.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_act_i  = 1'b0;
    w_act_d  = 1'b0;
    w_cnt    = r_cnt;
    w_d_pend = r_d_pend;
    w_d_rd   = r_d_rd;
    w_idx    = r_didx;
    w_we     = r_dwe;
    w_wdata  = r_din;
    case (r_state)
      ST_IDLE: begin
        w_act_i  = icache_re;
        w_act_d  = ~icache_re & w_in_d;
        w_cnt    = LAT_FULL;
        w_d_pend = w_in_d;
        w_d_rd   = w_in_drd;
        w_idx    = icache_re ? w_in_iidx : w_in_didx;
        w_we     = dcache_we;
        w_wdata  = dcache_din;
      end
      ST_I_ACC: begin
        w_act_i = 1'b1;
        w_idx   = r_iidx;
      end
      ST_D_ACC: w_act_d = 1'b1;
      default: ;
    endcase
  end

  assign w_done = (w_act_i | w_act_d) & (w_cnt == '0);

  // Next-state: finish the icache access into a pending dcache access, keep
  // counting an unfinished access, otherwise return to idle.
  always_comb begin
    w_state_nx = ST_IDLE;
    w_cnt_nx   = w_cnt - LAT_W'(1);
    if (w_act_i & w_done & w_d_pend) begin
      w_state_nx = ST_D_ACC;
      w_cnt_nx   = LAT_FULL;
    end else if (w_act_i & ~w_done) begin
      w_state_nx = ST_I_ACC;
    end else if (w_act_d & ~w_done) begin
      w_state_nx = ST_D_ACC;
    end
  end

  // A write lands only on its completing edge; reset on that edge drops it.
  assign w_ram_we = (w_act_d & w_done & ~rst) ? w_we : 4'b0000;
  assign w_ld_i   = w_act_i & w_done;
  assign w_ld_d   = w_act_d & w_done & w_d_rd;

  // State and latency counter; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Latch the request while idle; it is only consumed after a capture.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE) begin
      r_d_pend <= w_in_d;
      r_d_rd   <= w_in_drd;
      r_iidx   <= w_in_iidx;
      r_didx   <= w_in_didx;
      r_dwe    <= dcache_we;
      r_din    <= dcache_din;
    end
  end

  assign stall = (r_state != ST_IDLE);

  cache_stub_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .MEM_HEX   (MEM_HEX)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .i_idx    (w_idx),
    .i_we     (w_ram_we),
    .i_wdata  (w_wdata),
    .i_ld_i   (w_ld_i),
    .i_ld_d   (w_ld_d),
    .o_rdata_i(icache_dout),
    .o_rdata_d(dcache_dout)
  );

`ifdef CACHE_STUB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_acc;

  // Saturating stall-cycle and completed-access counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_acc   <= '0;
    end else begin
      if (stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_done && (r_perf_acc != '1))  r_perf_acc   <= r_perf_acc + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_accesses     = r_perf_acc;
`endif

endmodule

// File: tb/tb_cache_stub_mem.sv
// Self-checking bench for cache_stub_mem. Two instances (LATENCY=1 and
// LATENCY=4) share one stimulus stream; requests are issued only when both
// are idle. A reference model per instance pushes the expected douts and
// stall length into a queue; per-instance monitors pop and compare.
module tb_cache_stub_mem;

  typedef struct {
    logic [31:0] idout;
    logic [31:0] ddout;
    int          stall_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] idout [2];
  logic [31:0] ddout [2];
  logic        stall_s [2];
`ifdef CACHE_STUB_PERF_EN
  logic [31:0] perf_s [2];
  logic [31:0] perf_a [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: word contents and last read word per instance.
  logic [31:0] mem_m [2][4096];
  logic [31:0] exp_i [2];
  logic [31:0] exp_d [2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  cache_stub_mem #(.DEPTH_LOG2(12), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(idout[0]),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(ddout[0]), .stall(stall_s[0])
`ifdef CACHE_STUB_PERF_EN
    , .perf_stall_cycles(perf_s[0]), .perf_accesses(perf_a[0])
`endif
  );

  cache_stub_mem #(.DEPTH_LOG2(12), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(idout[1]),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(ddout[1]), .stall(stall_s[1])
`ifdef CACHE_STUB_PERF_EN
    , .perf_stall_cycles(perf_s[1]), .perf_accesses(perf_a[1])
`endif
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_pop(input int k);
    return (k == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Word index as the memory sees it: byte address / 4, modulo depth.
  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd4096);
  endfunction

  // Model one capture on instance k: icache read first, then the dcache
  // write (which wins over a read) or read; stall lasts LATENCY*n - 1.
  task automatic model_issue(input int k, input logic ire, input logic [31:0] ia,
                             input logic dre, input logic [3:0] dwe,
                             input logic [31:0] da, input logic [31:0] din);
    exp_t e;
    int   n = 0;
    int   iw = word_of(ia);
    int   dw = word_of(da);
    if (ire) begin
      exp_i[k] = mem_m[k][iw];
      n++;
    end
    if (dwe != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (dwe[b]) mem_m[k][dw][8*b +: 8] = din[8*b +: 8];
      n++;
    end else if (dre) begin
      exp_d[k] = mem_m[k][dw];
      n++;
    end
    e.idout = exp_i[k];
    e.ddout = exp_d[k];
    e.stall_cyc = (n == 0) ? 0 : lat_of(k) * n - 1;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: once a request is outstanding, count stall cycles and compare
  // both douts in the first cycle stall is low again.
  task automatic mon(input int k);
    int   cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_size(k) > 0) begin
        if (stall_s[k]) begin
          cnt++;
          if (cnt > 64) begin
            e = q_pop(k);
            check($sformatf("stall_timeout_l%0d", lat_of(k)), 32'(cnt), 32'(e.stall_cyc));
            cnt = 0;
          end
        end else begin
          e = q_pop(k);
          check($sformatf("icache_dout_l%0d", lat_of(k)), idout[k], e.idout);
          check($sformatf("dcache_dout_l%0d", lat_of(k)), ddout[k], e.ddout);
          check($sformatf("stall_len_l%0d", lat_of(k)), 32'(cnt), 32'(e.stall_cyc));
          cnt = 0;
        end
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (q_size(0) + q_size(1)) > 0; i++) @(posedge clk);
    if ((q_size(0) + q_size(1)) > 0) begin
      check("drain_timeout", 32'(q_size(0) + q_size(1)), 32'd0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic issue(input logic ire, input logic [31:0] ia, input logic dre,
                       input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] din);
    wait_idle();
    @(negedge clk);
    icache_re = ire; icache_addr = ia;
    dcache_re = dre; dcache_we = dwe; dcache_addr = da; dcache_din = din;
    @(posedge clk);
    #1;
    model_issue(0, ire, ia, dre, dwe, da, din);
    model_issue(1, ire, ia, dre, dwe, da, din);
    icache_re = 1'b0; dcache_re = 1'b0; dcache_we = 4'b0000;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    a[13:2] = 12'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    logic [31:0] ps [2];
    logic [31:0] pa [2];
    rst = 1'b1;
    icache_re = 1'b0; icache_addr = '0;
    dcache_re = 1'b0; dcache_we = 4'b0000; dcache_addr = '0; dcache_din = '0;
    for (int k = 0; k < 2; k++) begin
      exp_i[k] = '0;
      exp_d[k] = '0;
    end
    fork
      mon(0);
      mon(1);
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_stall_l%0d", lat_of(k)), 32'(stall_s[k]), 32'd0);
      check($sformatf("reset_idout_l%0d", lat_of(k)), idout[k], 32'd0);
      check($sformatf("reset_ddout_l%0d", lat_of(k)), ddout[k], 32'd0);
`ifdef CACHE_STUB_PERF_EN
      check($sformatf("reset_perf_stall_l%0d", lat_of(k)), perf_s[k], 32'd0);
      check($sformatf("reset_perf_acc_l%0d", lat_of(k)), perf_a[k], 32'd0);
`endif
    end
    rst = 1'b0;

    // Fill the working set of words 0..15.
    for (int w = 0; w < 16; w++) issue(1'b0, '0, 1'b0, 4'hF, 32'(w * 4), $urandom());

    // Idle cycle with no request must not stall.
    issue(1'b0, '0, 1'b0, 4'h0, '0, '0);

    // Byte-lane write over a known word.
    issue(1'b0, '0, 1'b0, 4'hF, 32'h10, 32'h1122_3344);
    issue(1'b0, '0, 1'b0, 4'b0010, 32'h10, 32'hAABB_CCDD);
    issue(1'b0, '0, 1'b1, 4'h0, 32'h10, '0);
    wait_idle();
    for (int k = 0; k < 2; k++)
      check($sformatf("byte_write_l%0d", lat_of(k)), ddout[k], 32'h1122_CC44);

    // Same-capture icache read and dcache write to word 8.
    issue(1'b0, '0, 1'b0, 4'hF, 32'h20, 32'h0123_4567);
    issue(1'b1, 32'h20, 1'b0, 4'hF, 32'h20, 32'hDEAD_BEEF);
    wait_idle();
    for (int k = 0; k < 2; k++)
      check($sformatf("hazard_old_l%0d", lat_of(k)), idout[k], 32'h0123_4567);
    issue(1'b0, '0, 1'b1, 4'h0, 32'h20, '0);
    wait_idle();
    for (int k = 0; k < 2; k++)
      check($sformatf("hazard_new_l%0d", lat_of(k)), ddout[k], 32'hDEAD_BEEF);

    // Address aliasing: 0x4010 reaches word 4.
    issue(1'b0, '0, 1'b0, 4'hF, 32'h0000_4010, 32'h5A5A_0004);
    issue(1'b0, '0, 1'b1, 4'h0, 32'h0000_0010, '0);
    wait_idle();
    for (int k = 0; k < 2; k++)
      check($sformatf("alias_l%0d", lat_of(k)), ddout[k], 32'h5A5A_0004);

    // Write and read on the dcache port together: write wins.
    issue(1'b0, '0, 1'b1, 4'hF, 32'h14, 32'h7777_1414);

    // Dual read; scoreboard checks 7 stall cycles at LATENCY=4.
    wait_idle();
`ifdef CACHE_STUB_PERF_EN
    for (int k = 0; k < 2; k++) begin
      ps[k] = perf_s[k];
      pa[k] = perf_a[k];
    end
`endif
    issue(1'b1, 32'h0, 1'b1, 4'h0, 32'h10, '0);
    wait_idle();
`ifdef CACHE_STUB_PERF_EN
    for (int k = 0; k < 2; k++) begin
      check($sformatf("perf_stall_delta_l%0d", lat_of(k)), perf_s[k] - ps[k],
            32'(2 * lat_of(k) - 1));
      check($sformatf("perf_acc_delta_l%0d", lat_of(k)), perf_a[k] - pa[k], 32'd2);
    end
`else
    ps[0] = '0; pa[0] = '0;
`endif

    // Reset on the 2nd stall cycle of a LATENCY=4 write aborts it; the
    // LATENCY=1 instance completes its write on the capture edge.
    @(negedge clk);
    dcache_we = 4'hF; dcache_addr = 32'h30; dcache_din = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    model_issue(0, 1'b0, '0, 1'b0, 4'hF, 32'h30, 32'hCAFE_F00D);
    dcache_we = 4'b0000;
    @(negedge clk);
    check("rst_pre_stall_l4", 32'(stall_s[1]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_stall_l4", 32'(stall_s[1]), 32'd0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_idout_l%0d", lat_of(k)), idout[k], 32'd0);
      check($sformatf("rst_ddout_l%0d", lat_of(k)), ddout[k], 32'd0);
      exp_i[k] = '0;
      exp_d[k] = '0;
    end
    rst = 1'b0;
    issue(1'b0, '0, 1'b1, 4'h0, 32'h30, '0);

    // Randomised traffic over the working set with aliased upper bits.
    for (int t = 0; t < 200; t++) begin
      logic [3:0] we;
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      issue(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), we,
            rand_addr(), $urandom());
    end
    wait_idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
